// File: rtl/status_arbiter.sv
// Round-robin arbiter committing requester flag updates (or a clear) to a status register.
// Latency: REQ/CLR sampled in IDLE -> GNT/SR_CE asserted 1 cycle later; one commit per 2 cycles max.
// Backpressure: REQ is a level held until granted; FREEZE stalls new grants/clears, in-flight commit completes.
//
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   REQ[NREQ]           per-requester update request
//   FLAGS[NREQ*FW]      per-requester flag vectors, requester i at [i*FW +: FW]
//   MODE[NREQ]          0 = overwrite, 1 = OR into current shadow value
//   CLR, FREEZE         clear command, grant/clear inhibit
//   GNT[NREQ]           one-hot grant pulse (registered)
//   SR_CE, SR_DIN[FW]   status register write enable / data (registered)
//   SHADOW[FW]          copy of the last value written through SR_DIN
//   COMMIT_CNT[8]       wrapping count of grants plus clears
module status_arbiter #(
    parameter int NREQ = 4,
    parameter int FW   = 5
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ*FW-1:0]   FLAGS,
    input  logic [NREQ-1:0]      MODE,
    input  logic                 CLR,
    input  logic                 FREEZE,
    output logic [NREQ-1:0]      GNT,
    output logic                 SR_CE,
    output logic [FW-1:0]        SR_DIN,
    output logic [FW-1:0]        SHADOW,
    output logic [7:0]           COMMIT_CNT
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;

    logic            hit;
    logic [PW-1:0]   win;
    logic [FW-1:0]   win_flags;
    logic [FW-1:0]   result;

    logic [NREQ-1:0] gnt_nxt;
    logic            ce_nxt;
    logic [FW-1:0]   din_nxt;
    logic [FW-1:0]   shadow_nxt;
    logic [7:0]      cnt_nxt;

    // Round-robin search: first asserted REQ scanning upward from ptr, wrapping.
    always_comb begin
        int idx;
        hit = 1'b0;
        win = '0;
        idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!hit && REQ[idx]) begin
                hit = 1'b1;
                win = PW'(idx);
            end
        end
    end

    assign win_flags = FLAGS[int'(win)*FW +: FW];
    // Sticky mode merges into the last committed value, which SHADOW holds.
    assign result    = MODE[win] ? (SHADOW | win_flags) : win_flags;

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        gnt_nxt    = '0;
        ce_nxt     = 1'b0;
        din_nxt    = SR_DIN;
        shadow_nxt = SHADOW;
        cnt_nxt    = COMMIT_CNT;
        case (state)
            IDLE: begin
                if (!FREEZE) begin
                    if (CLR) begin
                        // Clear beats every request; ptr is left where it was.
                        ce_nxt     = 1'b1;
                        din_nxt    = '0;
                        shadow_nxt = '0;
                        cnt_nxt    = COMMIT_CNT + 8'd1;
                        state_nxt  = GRANT;
                    end else if (hit) begin
                        gnt_nxt[win] = 1'b1;
                        ce_nxt       = 1'b1;
                        din_nxt      = result;
                        shadow_nxt   = result;
                        cnt_nxt      = COMMIT_CNT + 8'd1;
                        ptr_nxt      = PW'((int'(win) + 1) % NREQ);
                        state_nxt    = GRANT;
                    end
                end
            end
            GRANT: begin
                // Single-cycle pulse; all inputs ignored here so the commit cannot be cancelled.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ptr        <= '0;
            GNT        <= '0;
            SR_CE      <= 1'b0;
            SR_DIN     <= '0;
            SHADOW     <= '0;
            COMMIT_CNT <= 8'd0;
        end else begin
            ptr        <= ptr_nxt;
            GNT        <= gnt_nxt;
            SR_CE      <= ce_nxt;
            SR_DIN     <= din_nxt;
            SHADOW     <= shadow_nxt;
            COMMIT_CNT <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_status_arbiter.sv
// Directed bench for status_arbiter: table of single-commit vectors plus hand sequences
// for round-robin order, clear priority, freeze, counter wrap and asynchronous reset.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_status_arbiter;

    localparam int NREQ = 4;
    localparam int FW   = 5;

    logic                CLK;
    logic                RESET;
    logic [NREQ-1:0]     REQ;
    logic [NREQ*FW-1:0]  FLAGS;
    logic [NREQ-1:0]     MODE;
    logic                CLR;
    logic                FREEZE;
    logic [NREQ-1:0]     GNT;
    logic                SR_CE;
    logic [FW-1:0]       SR_DIN;
    logic [FW-1:0]       SHADOW;
    logic [7:0]          COMMIT_CNT;

    int tests = 0;
    int fails = 0;

    status_arbiter #(.NREQ(NREQ), .FW(FW)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ        (REQ),
        .FLAGS      (FLAGS),
        .MODE       (MODE),
        .CLR        (CLR),
        .FREEZE     (FREEZE),
        .GNT        (GNT),
        .SR_CE      (SR_CE),
        .SR_DIN     (SR_DIN),
        .SHADOW     (SHADOW),
        .COMMIT_CNT (COMMIT_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  req;
        logic [19:0] flags;
        logic [3:0]  mode;
        logic        clr;
        logic        frz;
        logic [3:0]  e_gnt;
        logic        e_ce;
        logic [4:0]  e_din;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        REQ    = '0;
        MODE   = '0;
        CLR    = 1'b0;
        FREEZE = 1'b0;
    endtask

    // Called at posedge+1: reset asserts mid-cycle and releases after the next edge.
    task automatic do_reset();
        idle_inputs();
        #2 RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b0;
        FLAGS = '0;
        idle_inputs();

        // Expected values worked out by hand from reset (ptr=0, shadow=0, count=0).
        //              req      flags{F3,F2,F1,F0}              mode     clr frz  gnt      ce  din    cnt
        tbl[0]  = '{4'b0001, {5'h00, 5'h00, 5'h00, 5'h15}, 4'b0000, 0, 0, 4'b0001, 1, 5'h15, 8'd1};
        tbl[1]  = '{4'b1000, {5'h0A, 5'h00, 5'h00, 5'h00}, 4'b1000, 0, 0, 4'b1000, 1, 5'h1F, 8'd2};
        tbl[2]  = '{4'b0110, {5'h00, 5'h10, 5'h04, 5'h00}, 4'b0000, 0, 0, 4'b0010, 1, 5'h04, 8'd3};
        tbl[3]  = '{4'b0011, {5'h00, 5'h00, 5'h1F, 5'h08}, 4'b0001, 0, 0, 4'b0001, 1, 5'h0C, 8'd4};
        tbl[4]  = '{4'b0100, {5'h00, 5'h1F, 5'h00, 5'h00}, 4'b0000, 1, 0, 4'b0000, 1, 5'h00, 8'd5};
        tbl[5]  = '{4'b0100, {5'h00, 5'h1F, 5'h00, 5'h00}, 4'b0000, 0, 1, 4'b0000, 0, 5'h00, 8'd5};
        tbl[6]  = '{4'b0000, {5'h00, 5'h00, 5'h00, 5'h00}, 4'b0000, 1, 1, 4'b0000, 0, 5'h00, 8'd5};
        tbl[7]  = '{4'b0000, {5'h00, 5'h00, 5'h00, 5'h00}, 4'b0000, 0, 0, 4'b0000, 0, 5'h00, 8'd5};
        tbl[8]  = '{4'b0100, {5'h00, 5'h03, 5'h00, 5'h00}, 4'b0000, 0, 0, 4'b0100, 1, 5'h03, 8'd6};
        tbl[9]  = '{4'b0100, {5'h00, 5'h10, 5'h00, 5'h00}, 4'b0100, 0, 0, 4'b0100, 1, 5'h13, 8'd7};
        tbl[10] = '{4'b0010, {5'h00, 5'h00, 5'h04, 5'h00}, 4'b0000, 0, 0, 4'b0010, 1, 5'h04, 8'd8};

        // Power-on reset.
        tick();
        do_reset();
        chk("rst_gnt",  32'(GNT),        32'h0);
        chk("rst_ce",   32'(SR_CE),      32'h0);
        chk("rst_din",  32'(SR_DIN),     32'h0);
        chk("rst_shd",  32'(SHADOW),     32'h0);
        chk("rst_cnt",  32'(COMMIT_CNT), 32'h0);

        // Table: apply one IDLE cycle of inputs, check the commit edge, then the return edge.
        for (int i = 0; i < 11; i++) begin
            REQ    = tbl[i].req;
            FLAGS  = tbl[i].flags;
            MODE   = tbl[i].mode;
            CLR    = tbl[i].clr;
            FREEZE = tbl[i].frz;
            tick();
            chk($sformatf("v%0d_gnt", i), 32'(GNT),        32'(tbl[i].e_gnt));
            chk($sformatf("v%0d_ce", i),  32'(SR_CE),      32'(tbl[i].e_ce));
            chk($sformatf("v%0d_din", i), 32'(SR_DIN),     32'(tbl[i].e_din));
            chk($sformatf("v%0d_shd", i), 32'(SHADOW),     32'(tbl[i].e_din));
            chk($sformatf("v%0d_cnt", i), 32'(COMMIT_CNT), 32'(tbl[i].e_cnt));
            idle_inputs();
            tick();
            chk($sformatf("v%0d_gnt_off", i), 32'(GNT),    32'h0);
            chk($sformatf("v%0d_ce_off", i),  32'(SR_CE),  32'h0);
            chk($sformatf("v%0d_din_hold", i), 32'(SR_DIN), 32'(tbl[i].e_din));
        end

        // Clear beats a simultaneous request; that request wins two cycles later.
        REQ   = 4'b0010;
        FLAGS = {5'h00, 5'h00, 5'h0B, 5'h00};
        CLR   = 1'b1;
        tick();
        chk("clr_gnt", 32'(GNT),    32'h0);
        chk("clr_ce",  32'(SR_CE),  32'h1);
        chk("clr_din", 32'(SR_DIN), 32'h0);
        CLR = 1'b0;
        tick();
        chk("clr_gap_gnt", 32'(GNT),   32'h0);
        chk("clr_gap_ce",  32'(SR_CE), 32'h0);
        tick();
        chk("clr_next_gnt", 32'(GNT),    32'h2);
        chk("clr_next_din", 32'(SR_DIN), 32'h0B);
        REQ = '0;
        tick();

        // Freeze holds off a pending request; release grants on the next edge.
        REQ    = 4'b0100;
        FLAGS  = {5'h00, 5'h07, 5'h00, 5'h00};
        FREEZE = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("frz%0d_gnt", c), 32'(GNT),   32'h0);
            chk($sformatf("frz%0d_ce", c),  32'(SR_CE), 32'h0);
        end
        FREEZE = 1'b0;
        tick();
        chk("frz_rel_gnt", 32'(GNT),    32'h4);
        chk("frz_rel_din", 32'(SR_DIN), 32'h07);
        // Freeze raised during the grant cycle must not stop the pulse from completing normally.
        REQ    = '0;
        FREEZE = 1'b1;
        tick();
        chk("frz_grant_end_ce", 32'(SR_CE), 32'h0);
        FREEZE = 1'b0;

        // Round robin with all requesters held high: 0,1,2,3,0 on alternate cycles.
        do_reset();
        FLAGS = {5'h04, 5'h03, 5'h02, 5'h01};
        REQ   = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c % 2 == 0) begin
                chk($sformatf("rr%0d_gnt", c), 32'(GNT),    32'h1 << ((c / 2) % 4));
                chk($sformatf("rr%0d_din", c), 32'(SR_DIN), 32'((c / 2) % 4 + 1));
            end else begin
                chk($sformatf("rr%0d_gnt", c), 32'(GNT), 32'h0);
            end
        end
        REQ = '0;
        tick();

        // 256 commits bring the counter back to zero.
        do_reset();
        FLAGS = {5'h00, 5'h00, 5'h00, 5'h01};
        REQ   = 4'b0001;
        for (int n = 1; n <= 256; n++) begin
            tick();
            if (n == 255) chk("wrap_255", 32'(COMMIT_CNT), 32'd255);
            if (n == 256) chk("wrap_0",   32'(COMMIT_CNT), 32'd0);
            @(posedge CLK);
            #1;
        end
        REQ = '0;
        tick();

        // Asynchronous reset in the middle of a grant pulse, then arbitration restarts at index 0.
        do_reset();
        REQ   = 4'b0010;
        FLAGS = {5'h00, 5'h00, 5'h09, 5'h00};
        tick();
        chk("ar_pre_gnt", 32'(GNT), 32'h2);
        REQ = '0;
        #2 RESET = 1'b1;
        #1;
        chk("ar_gnt", 32'(GNT),        32'h0);
        chk("ar_ce",  32'(SR_CE),      32'h0);
        chk("ar_din", 32'(SR_DIN),     32'h0);
        chk("ar_shd", 32'(SHADOW),     32'h0);
        chk("ar_cnt", 32'(COMMIT_CNT), 32'h0);
        tick();
        RESET = 1'b0;
        REQ   = 4'b0110;
        FLAGS = {5'h00, 5'h06, 5'h05, 5'h00};
        tick();
        chk("ar_ptr0_gnt", 32'(GNT),        32'h2);
        chk("ar_ptr0_din", 32'(SR_DIN),     32'h05);
        chk("ar_ptr0_cnt", 32'(COMMIT_CNT), 32'h1);
        REQ = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
